lfsr_generic: RTL

//  Parametrised LFSR with external entropy injection. It succeeds the fixed 16-bit Fibonacci LFSR.
//  - Width, polynomial, reset seed and topology (Fibonacci/Galois) are selectable.
//  - Supports runtime reseed and zero-state lockup recovery.
//  - A valid/ready word port guarantees each delivered word holds WIDTH fresh shifts.

---
 rtl/lfsr_generic.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/lfsr_generic.sv
// ---------------------------------------------------------------------------
// lfsr_generic
//
// Purpose:
//   Parametrised linear feedback shift register with external entropy
//   injection. Each enabled shift XORs the 'random_i' bit into the feedback.
//   A valid/ready word port marks a word as deliverable only once it holds
//   WIDTH shifts taken since the last reset, reseed or transfer. Runtime
//   reseed is supported. Optional zero-state lockup recovery is also
//   supported.
//
// Parameters:
//   WIDTH  state width, 4..64
//   POLY   feedback polynomial without the x^WIDTH term (bit k = coeff x^k),
//          POLY[0] must be 1
//   SEED   state after reset, nonzero
//   MODE   0 = Fibonacci, 1 = Galois
//
// Configuration macro:
//   LFSR_LOCKUP_RECOVERY_EN  when defined, an enabled shift that would keep
//                            the state at all-zero reloads SEED instead and
//                            sets the sticky lockup_o flag; when undefined,
//                            lockup_o is tied low and a zero state persists
//                            while random_i = 0.
//
// Ports:
//   clk_i        clock, all logic on the rising edge
//   rst_i        asynchronous active-high reset
//   en_i         shift enable, one shift per cycle while high
//   random_i     entropy bit XORed into the feedback on each shift
//   load_i       synchronous reseed request (priority over en_i)
//   seed_i       reseed value, sampled when load_i = 1
//   out_data_o   current state register
//   out_valid_o  word ready: WIDTH fresh shifts accumulated
//   out_ready_i  consumer accepts the word when out_valid_o && out_ready_i
//   lockup_o     sticky flag, zero-state recovery occurred
// ---------------------------------------------------------------------------
module lfsr_generic #(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] POLY  = 16'h6801,
    parameter logic [WIDTH-1:0] SEED  = 16'hACE1,
    parameter int unsigned      MODE  = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             random_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] seed_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             lockup_o
);

    localparam int unsigned     CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] shift_val;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             lockup_q, lockup_d;
    logic             fb;
    logic             xfer;
    logic             stuck;

    // Topology-specific feedback and shifted state.
    generate
        if (MODE == 0) begin : g_fib
            // Tap mask: x^WIDTH term mapped onto the MSB, the rest from POLY.
            localparam logic [WIDTH-1:0] TAPS = {1'b1, POLY[WIDTH-1:1]};
            assign fb        = random_i ^ (^(state_q & TAPS));
            assign shift_val = {state_q[WIDTH-2:0], fb};
        end else begin : g_gal
            assign fb = random_i ^ state_q[WIDTH-1];
            for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
                if (gi == 0) begin : g_lsb
                    assign shift_val[gi] = fb & POLY[gi];
                end else begin : g_upper
                    assign shift_val[gi] = state_q[gi-1] ^ (fb & POLY[gi]);
                end
            end
        end
    endgenerate

`ifdef LFSR_LOCKUP_RECOVERY_EN
    // The all-zero state only survives a shift when the feedback is zero too.
    assign stuck = (state_q == '0) && !fb;
`else
    assign stuck = 1'b0;
`endif

    assign xfer = out_valid_o && out_ready_i;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lockup_d = lockup_q;
        if (load_i) begin
            // Reseed wins over shifting; a coincident transfer still takes
            // the old state because out_data_o is the pre-edge register.
            state_d  = seed_i;
            cnt_d    = '0;
            lockup_d = 1'b0;
        end else begin
            if (en_i) begin
                if (stuck) begin
                    state_d  = SEED;
                    lockup_d = 1'b1;
                end else begin
                    state_d = shift_val;
                end
            end
            if (xfer) begin
                // A shift in the transfer cycle already belongs to the next word.
                cnt_d = en_i ? CNT_ONE : '0;
            end else if (en_i && (cnt_q != CNT_FULL)) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= SEED;
            cnt_q    <= '0;
            lockup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lockup_q <= lockup_d;
        end
    end

    assign out_data_o  = state_q;
    assign out_valid_o = (cnt_q == CNT_FULL);
    assign lockup_o    = lockup_q;

endmodule
